// File: rtl/alu_bit_serial_seq_pkg.sv
// Shared definitions for the bit-serial ALU sequencer.
//   - FS opcode constants (5-bit function-select encoding used by the 1-bit cell)
//   - Sequencer FSM state encoding
//   - Small opcode-classification helpers
//
// FS encoding:
//   fs[4] = 0        : logic op, fs[3:0] is the truth table indexed by {a,b}
//                      (F = fs[{a,b}], so 0110 is XOR, 1000 is AND, 1110 is OR, ...)
//   fs[4:3] = 10     : arithmetic F = A + Y + Cin, where
//                      Y = fs[2] ? (B ^ {fs[1]}) : {fs[1]}  (0, all-ones, B, ~B)
//   fs[4:3] = 11     : shift, fs[0] = 0 left (fill = cin), fs[0] = 1 right (fill = cin)
package alu_bit_serial_seq_pkg;

    localparam logic [4:0] FsInc = 5'b10000;  // A + cin  (increment with cin=1)
    localparam logic [4:0] FsDec = 5'b10010;  // A + all-ones + cin
    localparam logic [4:0] FsAdd = 5'b10100;  // A + B + cin
    localparam logic [4:0] FsSub = 5'b10110;  // A + ~B + cin (A-B with cin=1)
    localparam logic [4:0] FsShl = 5'b11000;
    localparam logic [4:0] FsShr = 5'b11001;
    localparam logic [4:0] FsAnd = 5'b01000;
    localparam logic [4:0] FsOr  = 5'b01110;
    localparam logic [4:0] FsXor = 5'b00110;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    function automatic logic is_logic_op(input logic [4:0] op);
        return ~op[4];
    endfunction

    function automatic logic is_shift_right(input logic [4:0] op);
        return op[4] & op[3] & op[0];
    endfunction

endpackage

// File: rtl/alu_bit_serial_seq_cell.sv
// One-bit ALU cell, driven once per clock by the bit-serial sequencer.
// Ports:
//   a, b       operand bits at the current index
//   fs         5-bit function select
//   c_in       carry-in (or shift-left fill / previous bit)
//   a_next     operand A bit from index+1 (or fill bit at the MSB), for shift-right
//   f          result bit
//   c_out      carry-out; for shifts, the A bit handed to the next index
module alu_bit_serial_seq_cell
    import alu_bit_serial_seq_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic [4:0] fs,
    input  logic       c_in,
    input  logic       a_next,
    output logic       f,
    output logic       c_out
);

    logic       y;
    logic [3:0] truth;

    always_comb begin
        y     = fs[2] ? (b ^ fs[1]) : fs[1];
        truth = fs[3:0];
        f     = 1'b0;
        c_out = 1'b0;
        if (is_logic_op(fs)) begin
            f = truth[{a, b}];
        end else if (!fs[3]) begin
            f     = a ^ y ^ c_in;
            c_out = (a & y) | (a & c_in) | (y & c_in);
        end else if (fs[0]) begin
            f     = a_next;
            c_out = a;
        end else begin
            // Shift left: the carry chain carries the previous A bit upward.
            f     = c_in;
            c_out = a;
        end
    end

endmodule

// File: rtl/alu_bit_serial_seq.sv
// Bit-serial ALU sequencer: walks one 1-bit ALU cell across a WIDTH-bit operand pair,
// LSB first, one bit per clock, registering carry and result bits between cycles.
// Ports:
//   clk, reset_n         clock (rising edge), asynchronous active-low reset
//   start                request, sampled only while ready=1
//   fs, a, b, cin        function select, operands, bit-0 carry / shift fill (latched on accept)
//   ready                high in IDLE only
//   busy                 high in RUN
//   done                 one-cycle pulse when f/c_out/zero are valid
//   f                    result, held from done until the next accept
//   c_out                carry / shift-out, 0 for logic ops
//   zero                 (f == 0)
module alu_bit_serial_seq
    import alu_bit_serial_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [4:0]       fs,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] f,
    output logic             c_out,
    output logic             zero
);

    localparam int unsigned     IdxW    = $clog2(WIDTH);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(WIDTH - 1);

    state_e          state_q, state_d;
    logic [IdxW-1:0] idx_q;
    logic [4:0]      fs_q;
    logic [WIDTH-1:0] a_q, b_q, f_q;
    logic            cin_q, carry_q, c_out_q;

    logic            accept, last_bit;
    logic            cell_f, cell_cout, cell_cin, cell_a_next, c_out_d;
    logic [WIDTH-1:0] a_shr;

    assign last_bit = (idx_q == LastIdx);

    // FSM next state and handshake outputs.
    always_comb begin
        state_d = state_q;
        ready   = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        accept  = 1'b0;
        unique case (state_q)
            StIdle: begin
                ready = 1'b1;
                if (start) begin
                    accept  = 1'b1;
                    state_d = StRun;
                end
            end
            StRun: begin
                busy = 1'b1;
                if (last_bit) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // a_shr[k] is A's bit k+1, with cin filling in above the MSB for shift-right.
    assign a_shr       = {cin_q, a_q[WIDTH-1:1]};
    assign cell_a_next = a_shr[idx_q];
    assign cell_cin    = (idx_q == '0) ? cin_q : carry_q;

    alu_bit_serial_seq_cell u_cell (
        .a      (a_q[idx_q]),
        .b      (b_q[idx_q]),
        .fs     (fs_q),
        .c_in   (cell_cin),
        .a_next (cell_a_next),
        .f      (cell_f),
        .c_out  (cell_cout)
    );

    always_comb begin
        c_out_d = cell_cout;
        if (is_logic_op(fs_q)) begin
            c_out_d = 1'b0;
        end else if (is_shift_right(fs_q)) begin
            c_out_d = a_q[0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx_q   <= '0;
            fs_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            cin_q   <= 1'b0;
            carry_q <= 1'b0;
            f_q     <= '0;
            c_out_q <= 1'b0;
        end else if (accept) begin
            fs_q  <= fs;
            a_q   <= a;
            b_q   <= b;
            cin_q <= cin;
            idx_q <= '0;
        end else if (busy) begin
            f_q[idx_q] <= cell_f;
            carry_q    <= cell_cout;
            idx_q      <= last_bit ? '0 : idx_q + IdxW'(1);
            if (last_bit) begin
                c_out_q <= c_out_d;
            end
        end
    end

    assign f     = f_q;
    assign c_out = c_out_q;
    assign zero  = (f_q == '0);

endmodule

// File: tb/tb_alu_bit_serial_seq.sv
// Directed self-checking bench for alu_bit_serial_seq at WIDTH=8.
module tb_alu_bit_serial_seq;
    import alu_bit_serial_seq_pkg::*;

    logic       clk;
    logic       reset_n;
    logic       start;
    logic [4:0] fs;
    logic [7:0] a, b;
    logic       cin;
    logic       ready, busy, done;
    logic [7:0] f;
    logic       c_out, zero;

    int n_cmp = 0;
    int n_bad = 0;

    alu_bit_serial_seq #(.WIDTH(8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .fs      (fs),
        .a       (a),
        .b       (b),
        .cin     (cin),
        .ready   (ready),
        .busy    (busy),
        .done    (done),
        .f       (f),
        .c_out   (c_out),
        .zero    (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one op and wait for done; lat is the cycle (1 = cycle after accept) of done,
    // or -1 if done never came.
    task automatic run_op(input logic [4:0] op, input logic [7:0] av, input logic [7:0] bv,
                          input logic ci, output logic [7:0] fo, output logic co,
                          output logic zo, output int lat);
        int n;
        n = 0;
        while (!ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!ready) check_eq("ready_wait", {31'd0, ready}, 32'd1);
        fs    = op;
        a     = av;
        b     = bv;
        cin   = ci;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = -1;
        fo  = 8'hxx;
        co  = 1'bx;
        zo  = 1'bx;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (done) begin
                lat = i;
                fo  = f;
                co  = c_out;
                zo  = zero;
                break;
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_ready"}, {31'd0, ready}, 32'd1);
        check_eq({tag, "_busy"},  {31'd0, busy},  32'd0);
        check_eq({tag, "_done"},  {31'd0, done},  32'd0);
        check_eq({tag, "_f"},     {24'd0, f},     32'd0);
        check_eq({tag, "_cout"},  {31'd0, c_out}, 32'd0);
        check_eq({tag, "_zero"},  {31'd0, zero},  32'd1);
    endtask

    typedef struct {
        logic [4:0] op;
        logic [7:0] av;
        logic [7:0] bv;
        logic       ci;
        logic [7:0] ef;
        logic       ec;
        logic       ez;
    } vec_t;

    vec_t vecs[7] = '{
        '{FsAdd, 8'h3C, 8'h05, 1'b0, 8'h41, 1'b0, 1'b0},
        '{FsSub, 8'h10, 8'h01, 1'b1, 8'h0F, 1'b1, 1'b0},
        '{FsAdd, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b1},
        '{FsShl, 8'h81, 8'h00, 1'b0, 8'h02, 1'b1, 1'b0},
        '{FsShr, 8'h81, 8'h00, 1'b1, 8'hC0, 1'b1, 1'b0},
        '{FsXor, 8'hF0, 8'hFF, 1'b0, 8'h0F, 1'b0, 1'b0},
        '{FsInc, 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b1}
    };

    initial begin
        logic [7:0] fo, ra, rb, exp_f, code4;
        logic       co, zo;
        int         lat, n_done;
        bit         saw_busy_drop;

        reset_n = 1'b0;
        start   = 1'b0;
        fs      = '0;
        a       = '0;
        b       = '0;
        cin     = 1'b0;
        @(negedge clk);
        check_reset_outputs("rst");
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("post_rst");

        // Directed arithmetic / shift / logic vectors.
        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].av, vecs[i].bv, vecs[i].ci, fo, co, zo, lat);
            check_eq($sformatf("v%0d_lat", i),  lat, 32'd9);
            check_eq($sformatf("v%0d_f", i),    {24'd0, fo}, {24'd0, vecs[i].ef});
            check_eq($sformatf("v%0d_cout", i), {31'd0, co}, {31'd0, vecs[i].ec});
            check_eq($sformatf("v%0d_zero", i), {31'd0, zo}, {31'd0, vecs[i].ez});
        end

        // All 16 logic codes: code bit m selects minterm m of {a,b}.
        for (int c = 0; c < 16; c++) begin
            ra    = 8'($urandom_range(0, 255));
            rb    = 8'($urandom_range(0, 255));
            code4 = 8'(c);
            exp_f = (code4[0] ? (~ra & ~rb) : 8'h00) | (code4[1] ? (~ra & rb) : 8'h00) |
                    (code4[2] ? (ra & ~rb) : 8'h00) | (code4[3] ? (ra & rb) : 8'h00);
            run_op({1'b0, code4[3:0]}, ra, rb, 1'b1, fo, co, zo, lat);
            check_eq($sformatf("logic%0d_f", c),    {24'd0, fo}, {24'd0, exp_f});
            check_eq($sformatf("logic%0d_cout", c), {31'd0, co}, 32'd0);
            check_eq($sformatf("logic%0d_zero", c), {31'd0, zo}, {31'd0, (exp_f == 8'h00)});
        end

        // start held high through RUN and DONE while operands change.
        @(negedge clk);
        fs    = FsAdd;
        a     = 8'h12;
        b     = 8'h34;
        cin   = 1'b0;
        start = 1'b1;
        @(posedge clk);
        n_done = 0;
        fo     = 8'hxx;
        saw_busy_drop = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            a = 8'hA5 ^ 8'(i);
            b = 8'h5A + 8'(i);
            if (i <= 8 && !busy) saw_busy_drop = 1'b1;
            if (done) begin
                n_done++;
                fo = f;
                check_eq("hold_ready_in_done", {31'd0, ready}, 32'd0);
            end
        end
        check_eq("hold_busy_run", {31'd0, saw_busy_drop}, 32'd0);
        check_eq("hold_one_done", n_done, 32'd1);
        check_eq("hold_f", {24'd0, fo}, 32'h46);
        @(negedge clk);
        check_eq("hold_ready_back", {31'd0, ready}, 32'd1);
        start = 1'b0;
        @(negedge clk);

        // Reset asserted mid-RUN at index 4.
        fs    = FsSub;
        a     = 8'h55;
        b     = 8'h11;
        cin   = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(negedge clk);
        check_eq("abort_busy_before", {31'd0, busy}, 32'd1);
        reset_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        n_done = 0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check_eq("abort_no_done", n_done, 32'd0);
        check_eq("abort_idle", {31'd0, ready}, 32'd1);

        run_op(FsSub, 8'h55, 8'h11, 1'b1, fo, co, zo, lat);
        check_eq("after_abort_lat",  lat, 32'd9);
        check_eq("after_abort_f",    {24'd0, fo}, 32'h44);
        check_eq("after_abort_cout", {31'd0, co}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
